// File: rtl/neuron_mac_acc.sv
// Q-format multiply-accumulate neuron with bias add and saturation, feeding the sigmoid LUT.
// Optional MAC_ROUND_EN: round half up on each product instead of truncating toward -inf.
module neuron_mac_acc #(
    parameter  int DATA_W  = 16,
    parameter  int FRAC    = 9,
    parameter  int ACC_W   = 32,
    parameter  int MAX_LEN = 256,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_act,
    input  logic [DATA_W-1:0] in_wgt,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_x,
    output logic [CNT_W-1:0]  out_len,
    output logic              out_trunc
);

    typedef enum logic {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t                    r_state;
    state_t                    w_next_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic [DATA_W-1:0]         r_out_x;
    logic [CNT_W-1:0]          r_out_len;
    logic                      r_out_trunc;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [2*DATA_W-1:0] w_prod_adj;
    logic signed [2*DATA_W-1:0] w_shift;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [ACC_W-1:0]    w_sum;
    logic [DATA_W-1:0]          w_sat;
    logic [CNT_W-1:0]           w_cnt_inc;
    logic                       w_accept;
    logic                       w_terminate;

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // a result transfers where out_valid && out_ready. Both readies/valids are
    // pure decodes of r_state, so neither side sees a combinational path.
    assign in_ready  = (r_state == S_ACC);
    assign out_valid = (r_state == S_HOLD);
    assign out_x     = r_out_x;
    assign out_len   = r_out_len;
    assign out_trunc = r_out_trunc;

    assign w_prod = $signed(in_act) * $signed(in_wgt);

`ifdef MAC_ROUND_EN
    localparam logic signed [2*DATA_W-1:0] RND_HALF = (2*DATA_W)'(64'sd1 <<< (FRAC - 1));
    assign w_prod_adj = w_prod + RND_HALF;
`else
    assign w_prod_adj = w_prod;
`endif

    assign w_shift     = w_prod_adj >>> FRAC;
    assign w_term      = ACC_W'(w_shift);
    assign w_acc_next  = r_acc + w_term;
    assign w_sum       = w_acc_next + ACC_W'($signed(in_bias));
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_accept    = in_valid && (r_state == S_ACC);
    assign w_terminate = w_accept && (in_last || (w_cnt_inc == CNT_W'(MAX_LEN)));

    always_comb begin
        w_sat = w_sum[DATA_W-1:0];
        if (w_sum > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_ACC:   if (w_terminate) w_next_state = S_HOLD;
            S_HOLD:  if (out_ready)   w_next_state = S_ACC;
            default: w_next_state = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_x     <= '0;
            r_out_len   <= '0;
            r_out_trunc <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_terminate) begin
                r_out_x     <= w_sat;
                r_out_len   <= w_cnt_inc;
                r_out_trunc <= ~in_last;
                r_acc       <= '0;
                r_cnt       <= '0;
            end else if (w_accept) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Bench for neuron_mac_acc: directed cases plus random bursts checked against an arithmetic model.
// The model follows MAC_ROUND_EN the same way the design build does.
module tb_neuron_mac_acc;
    localparam int DATA_W  = 16;
    localparam int FRAC    = 9;
    localparam int ACC_W   = 32;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_act;
    logic [DATA_W-1:0] in_wgt;
    logic              in_last;
    logic [DATA_W-1:0] in_bias;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_x;
    logic [CNT_W-1:0]  out_len;
    logic              out_trunc;

    int n_checks = 0;
    int n_pass   = 0;
    int m_acc    = 0;
    int m_cnt    = 0;
    int rdy_mode = 0;          // 0 random, 1 stall, 2 always accept
    logic [31:0] exp_q[$];     // {x[19:4], len[3:1], trunc[0]}

    neuron_mac_acc #(
        .DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last), .in_bias(in_bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_len(out_len), .out_trunc(out_trunc)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // reference model: whole-number arithmetic on real Q6.9 values
    function automatic void model_beat(input logic [15:0] a, input logic [15:0] w,
                                       input logic [15:0] b, input logic last);
        longint p;
        longint t;
        int     s;
        logic [15:0] x;
        p = longint'($signed(a)) * longint'($signed(w));
`ifdef MAC_ROUND_EN
        p = p + (longint'(1) << (FRAC - 1));
`endif
        t = p >>> FRAC;
        m_acc = m_acc + int'(t);
        m_cnt++;
        if (last || m_cnt == MAX_LEN) begin
            s = m_acc + int'($signed(b));
            if (s > 32767) x = 16'h7FFF;
            else if (s < -32768) x = 16'h8000;
            else x = s[15:0];
            exp_q.push_back({12'd0, x, 3'(m_cnt), ~last});
            m_acc = 0;
            m_cnt = 0;
        end
    endfunction

    // scoreboard / downstream sink
    initial begin
        logic [31:0] e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
            if (!rst && out_valid && out_ready) begin
                check("result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_out_x", 32'(out_x), 32'(e[19:4]));
                    check("sb_out_len", 32'(out_len), 32'(e[3:1]));
                    check("sb_out_trunc", 32'(out_trunc), 32'(e[0]));
                end
            end
        end
    end

    // driver tasks
    task automatic send(input logic [15:0] a, input logic [15:0] w,
                        input logic [15:0] b, input logic last);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_act = a; in_wgt = w; in_bias = b; in_last = last;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("in_ready_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        model_beat(a, w, b, last);
        #1 in_valid = 1'b0;
    endtask

    task automatic expect_now(input string tag, input logic [15:0] x,
                              input logic [2:0] len, input logic trunc);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_x"}, 32'(out_x), 32'(x));
        check({tag, "_len"}, 32'(out_len), 32'(len));
        check({tag, "_trunc"}, 32'(out_trunc), 32'(trunc));
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_x"}, 32'(out_x), 32'd0);
        check({tag, "_out_len"}, 32'(out_len), 32'd0);
        check({tag, "_out_trunc"}, 32'(out_trunc), 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rw;
        logic [15:0] rb;
        int          len;
        logic        no_last;

        rst = 1'b1; in_valid = 1'b0; in_act = '0; in_wgt = '0; in_last = 1'b0; in_bias = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // mixed-sign burst of three
        send(16'h0200, 16'h0200, 16'h0000, 1'b0);
        send(16'h0400, 16'h0100, 16'h0000, 1'b0);
        send(16'hFF00, 16'h0200, 16'h0000, 1'b1);
        expect_now("basic", 16'h0300, 3'd3, 1'b0);
        drain();

        // positive and negative saturation, in_last coinciding with MAX_LEN
        for (int i = 0; i < 4; i++) send(16'h1000, 16'h1000, 16'h0000, i == 3);
        expect_now("sat_pos", 16'h7FFF, 3'd4, 1'b0);
        for (int i = 0; i < 4; i++) send(16'h1000, 16'hF000, 16'h0000, i == 3);
        expect_now("sat_neg", 16'h8000, 3'd4, 1'b0);
        drain();

        // bias cancels product; result held under backpressure
        rdy_mode = 1;
        send(16'h0200, 16'h0200, 16'hFE00, 1'b1);
        expect_now("bias", 16'h0000, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_act = 16'h0200; in_wgt = 16'h0200; in_last = 1'b1;
            @(negedge clk);
            check("hold_x", 32'(out_x), 32'h0000);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        rdy_mode = 2;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        rdy_mode = 0;
        drain();

        // sub-LSB products: truncation vs rounding
        for (int i = 0; i < 4; i++) send(16'h0010, 16'h0010, 16'h0000, i == 3);
`ifdef MAC_ROUND_EN
        expect_now("small_pos", 16'h0004, 3'd4, 1'b0);
`else
        expect_now("small_pos", 16'h0000, 3'd4, 1'b0);
`endif
        send(16'hFFF0, 16'h0010, 16'h0000, 1'b1);
`ifdef MAC_ROUND_EN
        expect_now("small_neg", 16'h0000, 3'd1, 1'b0);
`else
        expect_now("small_neg", 16'hFFFF, 3'd1, 1'b0);
`endif
        drain();

        // forced termination at MAX_LEN; next beat held off
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) send(16'h0200, 16'h0200, 16'h0000, 1'b0);
        expect_now("trunc", 16'h0800, 3'd4, 1'b1);
        in_valid = 1'b1; in_act = 16'h0200; in_wgt = 16'h0200; in_bias = 16'h0000; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("trunc_hold_in_ready", 32'(in_ready), 32'd0);
        end
        rdy_mode = 0;
        send(16'h0200, 16'h0200, 16'h0000, 1'b1);
        drain();

        // reset mid-burst discards partial sum
        send(16'h0300, 16'h0200, 16'h0000, 1'b0);
        send(16'h0300, 16'h0200, 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 m_acc = 0; m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("mid_reset");
        send(16'h0200, 16'h0200, 16'h0000, 1'b1);
        expect_now("after_reset", 16'h0200, 3'd1, 1'b0);
        drain();

        // random bursts
        for (int n = 0; n < 60; n++) begin
            len = $urandom_range(1, 4);
            no_last = (len == 4) && ($urandom_range(0, 2) == 0);
            rb = 16'($urandom);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ra = 16'($urandom);
                    rw = 16'($urandom);
                end else begin
                    ra = 16'($urandom_range(0, 4095) - 2048);
                    rw = 16'($urandom_range(0, 4095) - 2048);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(ra, rw, rb, (i == len - 1) && !no_last);
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
